// File: rtl/tlb_ctrl.sv
// Lookup/walk/fill sequencer and two-port round-robin arbiter for a shared TLB.
// Also sequences whole-TLB flushes once the in-flight transaction has drained.
module tlb_ctrl #(
   parameter int TAG_RAM_ADDR_WIDTH = 6,
   parameter int VPN_WIDTH          = 20,
   parameter int PAYLOAD_WIDTH      = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [1:0]                    req_valid_i,
   input  logic [2*VPN_WIDTH-1:0]        req_vpn_i,
   output logic [1:0]                    req_ready_o,
   output logic [1:0]                    resp_valid_o,
   output logic [PAYLOAD_WIDTH-1:0]      resp_payload_o,
   output logic                          resp_fault_o,
   input  logic                          flush_i,
   output logic                          flush_ack_o,
   output logic                          walk_req_o,
   output logic [VPN_WIDTH-1:0]          walk_vpn_o,
   input  logic                          walk_done_i,
   input  logic                          walk_fault_i,
   input  logic [PAYLOAD_WIDTH-1:0]      walk_pte_i,
   output logic [TAG_RAM_ADDR_WIDTH-1:0] tlb_idx_o,
   output logic [VPN_WIDTH-1:0]          tlb_tag_o,
   output logic [PAYLOAD_WIDTH-1:0]      tlb_payload_o,
   output logic                          tlb_we_o,
   output logic                          tlb_valid_o,
   output logic                          tlb_flush_o,
   input  logic                          tlb_hit_i,
   input  logic [PAYLOAD_WIDTH-1:0]      tlb_payload_i
);

   typedef enum logic [2:0] {IDLE, LOOKUP, WALK, FILL, FAULT, FLUSH} state_t;

   state_t                   state, state_nxt;
   logic                     cur_port;
   logic                     last_grant;
   logic                     flush_pend;
   logic [VPN_WIDTH-1:0]     cur_vpn;
   logic [PAYLOAD_WIDTH-1:0] cur_pte;
   logic                     grant_vld;
   logic                     grant_port;
   logic [VPN_WIDTH-1:0]     grant_vpn;

   // A lone requester wins outright; on a tie the port not granted last time wins.
   always_comb begin
      if (req_valid_i == 2'b11) grant_port = ~last_grant;
      else                      grant_port = req_valid_i[1];
      grant_vpn = grant_port ? req_vpn_i[2*VPN_WIDTH-1:VPN_WIDTH] : req_vpn_i[VPN_WIDTH-1:0];
      grant_vld = (state == IDLE) && !reset && !flush_pend && !flush_i && (req_valid_i != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // cur_vpn is reset too so the always-driven TLB index/tag come up as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_port   <= 1'b0;
         cur_vpn    <= '0;
         cur_pte    <= '0;
         last_grant <= 1'b1;
         flush_pend <= 1'b0;
      end else begin
         if (grant_vld) begin
            cur_port   <= grant_port;
            cur_vpn    <= grant_vpn;
            last_grant <= grant_port;
         end
         if (state == WALK && walk_done_i && !walk_fault_i) cur_pte <= walk_pte_i;
         if (state == FLUSH) flush_pend <= 1'b0;
         else if (flush_i)   flush_pend <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (flush_pend || flush_i) state_nxt = FLUSH;
            else if (grant_vld)        state_nxt = LOOKUP;
         end
         LOOKUP:  state_nxt = tlb_hit_i ? IDLE : WALK;
         WALK: begin
            if (walk_done_i) state_nxt = walk_fault_i ? FAULT : FILL;
         end
         FILL:    state_nxt = LOOKUP;
         FAULT:   state_nxt = IDLE;
         FLUSH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o    = 2'b00;
      resp_valid_o   = 2'b00;
      resp_payload_o = '0;
      resp_fault_o   = 1'b0;
      flush_ack_o    = 1'b0;
      walk_req_o     = 1'b0;
      walk_vpn_o     = '0;
      tlb_idx_o      = cur_vpn[TAG_RAM_ADDR_WIDTH-1:0];
      tlb_tag_o      = cur_vpn;
      tlb_payload_o  = '0;
      tlb_we_o       = 1'b0;
      tlb_valid_o    = 1'b0;
      tlb_flush_o    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld) req_ready_o = grant_port ? 2'b10 : 2'b01;
         end
         LOOKUP: begin
            if (tlb_hit_i) begin
               resp_valid_o   = cur_port ? 2'b10 : 2'b01;
               resp_payload_o = tlb_payload_i;
            end
         end
         WALK: begin
            walk_req_o = 1'b1;
            walk_vpn_o = cur_vpn;
         end
         FILL: begin
            tlb_we_o      = 1'b1;
            tlb_valid_o   = 1'b1;
            tlb_payload_o = cur_pte;
         end
         FAULT: begin
            resp_valid_o = cur_port ? 2'b10 : 2'b01;
            resp_fault_o = 1'b1;
         end
         FLUSH: begin
            tlb_flush_o = 1'b1;
            flush_ack_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Randomized bench for tlb_ctrl: behavioural TLB RAM and walker around the DUT,
// with a direct-mapped translation model predicting hits, walks and responses.
module tb_tlb_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid_i;
   logic [39:0] req_vpn_i;
   logic [1:0]  req_ready_o;
   logic [1:0]  resp_valid_o;
   logic [31:0] resp_payload_o;
   logic        resp_fault_o;
   logic        flush_i;
   logic        flush_ack_o;
   logic        walk_req_o;
   logic [19:0] walk_vpn_o;
   logic        walk_done_i;
   logic        walk_fault_i;
   logic [31:0] walk_pte_i;
   logic [5:0]  tlb_idx_o;
   logic [19:0] tlb_tag_o;
   logic [31:0] tlb_payload_o;
   logic        tlb_we_o;
   logic        tlb_valid_o;
   logic        tlb_flush_o;
   logic        tlb_hit_i;
   logic [31:0] tlb_payload_i;

   tlb_ctrl #(.TAG_RAM_ADDR_WIDTH(6), .VPN_WIDTH(20), .PAYLOAD_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_vpn_i(req_vpn_i), .req_ready_o(req_ready_o),
      .resp_valid_o(resp_valid_o), .resp_payload_o(resp_payload_o), .resp_fault_o(resp_fault_o),
      .flush_i(flush_i), .flush_ack_o(flush_ack_o),
      .walk_req_o(walk_req_o), .walk_vpn_o(walk_vpn_o), .walk_done_i(walk_done_i),
      .walk_fault_i(walk_fault_i), .walk_pte_i(walk_pte_i),
      .tlb_idx_o(tlb_idx_o), .tlb_tag_o(tlb_tag_o), .tlb_payload_o(tlb_payload_o),
      .tlb_we_o(tlb_we_o), .tlb_valid_o(tlb_valid_o), .tlb_flush_o(tlb_flush_o),
      .tlb_hit_i(tlb_hit_i), .tlb_payload_i(tlb_payload_i)
   );

   always #5 clk = ~clk;

   int n_vec;
   int n_err;
   int walk_delay;
   int wcnt;
   int exp_last;
   logic [31:0] pte_map [int];
   bit          fault_map [int];
   logic [19:0] exp_tlb [int];

   function automatic logic [31:0] pte_of(input logic [19:0] v);
      if (pte_map.exists(int'(v))) return pte_map[int'(v)];
      return {v[11:0], v} ^ 32'hA5A5_0F0F;
   endfunction

   // TLB RAM as integration wires it: flush clears every valid bit.
   bit        ram_v   [64];
   bit [19:0] ram_tag [64];
   bit [31:0] ram_dat [64];
   always @(posedge clk) begin
      if (tlb_flush_o) begin
         for (int i = 0; i < 64; i++) ram_v[i] <= 1'b0;
      end else if (tlb_we_o && tlb_valid_o) begin
         ram_v[tlb_idx_o]   <= 1'b1;
         ram_tag[tlb_idx_o] <= tlb_tag_o;
         ram_dat[tlb_idx_o] <= tlb_payload_o;
      end
   end
   assign tlb_hit_i     = ram_v[tlb_idx_o] && (ram_tag[tlb_idx_o] == tlb_tag_o);
   assign tlb_payload_i = ram_dat[tlb_idx_o];

   // Page-table walker: answers walk_delay cycles after the request, junk otherwise.
   initial begin
      walk_done_i = 1'b0; walk_fault_i = 1'b0; walk_pte_i = '0; wcnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            walk_done_i = 1'b0; wcnt = 0;
         end else if (walk_done_i) begin
            walk_done_i = 1'b0; wcnt = 0;
         end else if (walk_req_o) begin
            wcnt++;
            if (wcnt >= walk_delay) begin
               walk_done_i  = 1'b1;
               walk_fault_i = fault_map.exists(int'(walk_vpn_o));
               walk_pte_i   = pte_of(walk_vpn_o);
            end
         end else begin
            wcnt = 0;
         end
         if (!walk_done_i) begin
            walk_pte_i   = $urandom;
            walk_fault_i = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One request from acceptance to response, checked against the model.
   task automatic run_txn(input int port, input logic [19:0] vpn, input bit inj_flush);
      int          idx;
      bit          exp_hit, exp_fault, got, walked, flushed;
      logic [31:0] exp_pte;
      int          exp_lat, lat, we_cnt;
      logic [1:0]  onehot;
      idx       = int'(vpn[5:0]);
      exp_hit   = exp_tlb.exists(idx) && (exp_tlb[idx] == vpn);
      exp_fault = !exp_hit && fault_map.exists(int'(vpn));
      exp_pte   = exp_fault ? 32'h0 : pte_of(vpn);
      exp_lat   = exp_hit ? 1 : (exp_fault ? walk_delay + 2 : walk_delay + 3);
      onehot    = (port == 0) ? 2'b01 : 2'b10;
      req_valid_i[port] = 1'b1;
      req_vpn_i[port*20 +: 20] = vpn;
      #1;
      got = (req_ready_o == onehot);
      for (int n = 0; n < 20 && !got; n++) begin
         @(posedge clk); #1;
         got = (req_ready_o == onehot);
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL accept port%0d vpn %h: req_ready_o %b, required %b", port, vpn, req_ready_o, onehot);
         req_valid_i[port] = 1'b0;
         return;
      end
      exp_last = port;
      if (!exp_hit && !exp_fault) exp_tlb[idx] = vpn;
      got = 0; walked = 0; flushed = 0; we_cnt = 0; lat = 0;
      for (int n = 1; n <= 60 && !got; n++) begin
         @(posedge clk); #1;
         if (walk_req_o && !walked) begin
            walked = 1;
            n_vec++;
            if (walk_vpn_o !== vpn) begin
               n_err++;
               $display("FAIL walk_vpn: got %h, required %h", walk_vpn_o, vpn);
            end
         end
         if (tlb_we_o) begin
            we_cnt++;
            n_vec++;
            if ({tlb_valid_o, tlb_idx_o, tlb_tag_o, tlb_payload_o} !== {1'b1, vpn[5:0], vpn, pte_of(vpn)}) begin
               n_err++;
               $display("FAIL fill: got v%b idx %h tag %h pte %h, required v1 idx %h tag %h pte %h",
                        tlb_valid_o, tlb_idx_o, tlb_tag_o, tlb_payload_o, vpn[5:0], vpn, pte_of(vpn));
            end
         end
         if (resp_valid_o != 2'b00) begin got = 1; lat = n; end
         req_valid_i[port] = 1'b0;
         flush_i = 1'b0;
         if (inj_flush && !flushed && walk_req_o) begin flush_i = 1'b1; flushed = 1; end
      end
      flush_i = 1'b0;
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL response timeout port%0d vpn %h", port, vpn);
         return;
      end
      n_vec++;
      if ({resp_valid_o, resp_payload_o, resp_fault_o} !== {onehot, exp_pte, exp_fault}) begin
         n_err++;
         $display("FAIL response vpn %h: got valid %b pte %h fault %b, required valid %b pte %h fault %b",
                  vpn, resp_valid_o, resp_payload_o, resp_fault_o, onehot, exp_pte, exp_fault);
      end
      n_vec++;
      if (lat != exp_lat || walked != !exp_hit || we_cnt != ((exp_hit || exp_fault) ? 0 : 1)) begin
         n_err++;
         $display("FAIL path vpn %h: latency %0d walked %0d fills %0d, required %0d %0d %0d",
                  vpn, lat, walked, we_cnt, exp_lat, !exp_hit, (exp_hit || exp_fault) ? 0 : 1);
      end
      if (flushed) begin
         @(posedge clk); #1;
         n_vec++;
         if (flush_ack_o !== 1'b0) begin n_err++; $display("FAIL flush early: ack %b, required 0", flush_ack_o); end
         @(posedge clk); #1;
         n_vec++;
         if ({flush_ack_o, tlb_flush_o} !== 2'b11) begin
            n_err++; $display("FAIL flush pulse: ack/flush %b, required 11", {flush_ack_o, tlb_flush_o});
         end
         @(posedge clk); #1;
         n_vec++;
         if (flush_ack_o !== 1'b0) begin n_err++; $display("FAIL flush width: ack %b, required 0", flush_ack_o); end
         exp_tlb.delete();
      end
   endtask

   task automatic check_all_zero(input string name);
      n_vec++;
      if ({req_ready_o, resp_valid_o, resp_payload_o, resp_fault_o, flush_ack_o, walk_req_o, walk_vpn_o,
           tlb_idx_o, tlb_tag_o, tlb_payload_o, tlb_we_o, tlb_valid_o, tlb_flush_o} !== '0) begin
         n_err++;
         $display("FAIL %s: outputs not all zero (walk_req %b resp %b ready %b idx %h tag %h)",
                  name, walk_req_o, resp_valid_o, req_ready_o, tlb_idx_o, tlb_tag_o);
      end
   endtask

   task automatic test_reset();
      check_all_zero("reset_held");
      reset = 1'b0;
      #1;
      check_all_zero("reset_idle");
   endtask

   task automatic test_walk_fill();
      walk_delay = 3;
      pte_map[32'h41] = 32'h0200_00CF;
      run_txn(0, 20'h00041, 0);
      run_txn(0, 20'h00041, 0);
   endtask

   task automatic test_fault();
      fault_map[32'h777] = 1'b1;
      walk_delay = 2;
      run_txn(1, 20'h00777, 0);
      run_txn(1, 20'h00777, 0);
   endtask

   task automatic test_conflict();
      walk_delay = 1;
      run_txn(0, 20'h00005, 0);
      run_txn(1, 20'h00045, 0);
      run_txn(0, 20'h00005, 0);
   endtask

   task automatic test_back_to_back();
      logic [19:0] va, vb, v;
      bit          got;
      int          p;
      logic [1:0]  oh;
      va = 20'h00123; vb = 20'h00456;
      run_txn(0, va, 0);
      run_txn(1, vb, 0);
      req_vpn_i   = {vb, va};
      req_valid_i = 2'b11;
      for (int k = 0; k < 8; k++) begin
         got = 0;
         for (int n = 0; n < 10 && !got; n++) begin
            if (n > 0) @(posedge clk);
            #1;
            got = (req_ready_o != 2'b00);
         end
         p  = (exp_last == 0) ? 1 : 0;
         oh = (p == 0) ? 2'b01 : 2'b10;
         v  = (p == 0) ? va : vb;
         n_vec++;
         if (req_ready_o !== oh) begin
            n_err++;
            $display("FAIL rr_grant %0d: got %b, required %b", k, req_ready_o, oh);
         end
         exp_last = p;
         @(posedge clk); #1;
         n_vec++;
         if ({resp_valid_o, resp_payload_o, resp_fault_o} !== {oh, pte_of(v), 1'b0}) begin
            n_err++;
            $display("FAIL rr_resp %0d: got %b %h %b, required %b %h 0", k, resp_valid_o, resp_payload_o,
                     resp_fault_o, oh, pte_of(v));
         end
      end
      req_valid_i = 2'b00;
   endtask

   task automatic test_flush_walk();
      walk_delay = 3;
      run_txn(0, 20'h00ABC, 1);
      run_txn(0, 20'h00ABC, 0);
      run_txn(1, 20'h00041, 0);
   endtask

   task automatic test_flush_idle();
      @(posedge clk); #1;
      flush_i = 1'b1;
      req_valid_i[1] = 1'b1;
      req_vpn_i[39:20] = 20'h00ABC;
      #1;
      n_vec++;
      if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL flush_prio: ready %b, required 00", req_ready_o); end
      @(posedge clk); #1;
      flush_i = 1'b0;
      n_vec++;
      if ({flush_ack_o, tlb_flush_o, req_ready_o} !== 4'b1100) begin
         n_err++;
         $display("FAIL flush_idle: ack/flush/ready %b, required 1100", {flush_ack_o, tlb_flush_o, req_ready_o});
      end
      exp_tlb.delete();
      @(posedge clk);
      run_txn(1, 20'h00ABC, 0);
   endtask

   task automatic test_reset_mid_walk();
      bit seen;
      walk_delay = 4;
      @(posedge clk); #1;
      req_valid_i[0] = 1'b1;
      req_vpn_i[19:0] = 20'h3C3C3;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(posedge clk); #1;
         seen = walk_req_o;
      end
      n_vec++;
      if (!seen) begin n_err++; $display("FAIL reset_walk: walk_req_o never asserted"); end
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("reset_mid_walk");
      reset = 1'b0;
      exp_last = 1;
      run_txn(0, 20'h3C3C3, 0);
   endtask

   task automatic test_random();
      logic [19:0] pool [8];
      pool = '{20'h00010, 20'h00050, 20'h12345, 20'h00345, 20'h0ABCD, 20'h1FFFF, 20'h00000, 20'h40000};
      fault_map[32'h1FFFF] = 1'b1;
      fault_map[32'h40000] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         walk_delay = $urandom_range(1, 4);
         run_txn($urandom_range(0, 1), pool[$urandom_range(0, 7)], $urandom_range(0, 5) == 0);
      end
   endtask

   initial begin
      reset = 1'b1; req_valid_i = 2'b00; req_vpn_i = '0; flush_i = 1'b0;
      walk_delay = 3; n_vec = 0; n_err = 0; exp_last = 1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_walk_fill();
      test_back_to_back();
      test_fault();
      test_conflict();
      test_flush_walk();
      test_flush_idle();
      test_reset_mid_walk();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
